ready_responder: RTL and testbench

- Responder end of the single-cycle request/ready handshake.
- Drives `ready` toward a requester and accepts one-cycle `request` pulses while ready.
- After each accepted request, holds `ready` low for a pseudo-random service time, then re-offers `ready`.
- Counts accepted requests and flags protocol violations (request while not ready) and requester inactivity (timeout). Used as a synthesizable DUT partner for handshake and SVA benches.

---
 rtl/ready_responder_pkg.sv | 21 ++
 rtl/resp_lfsr16.sv | 31 +++
 rtl/ready_responder.sv | 144 ++++++++++++++
 tb/tb_ready_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ready_responder_pkg.sv
// Shared types and helpers for the ready/request responder and its LFSR.
package ready_responder_pkg;

  // Responder handshake state.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_READY = 2'd1,
    ST_BUSY  = 2'd2
  } resp_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Saturating increment. Works on 32-bit containers, so callers narrower
  // than 32 bits pass their all-ones value as the ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/resp_lfsr16.sv
// 16-bit Galois LFSR that advances one step per asserted step_i.
module resp_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_i,
  output logic [15:0] state_o
);
  import ready_responder_pkg::*;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: shift right, fold the outgoing bit back through the taps.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // State register; a nonzero seed keeps the sequence out of the all-zero lockup.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/ready_responder.sv
// Responder side of a single-cycle request/ready handshake with a
// pseudo-random service time, error flagging and saturating counters.
// CNT_W is limited to 32 bits by the shared saturation helper.
module ready_responder #(
  parameter int          MIN_BUSY  = 2,
  parameter int          MAX_BUSY  = 9,
  parameter int          TIMEOUT   = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             request,
  output logic             ready,
  output logic             accepted,
  output logic             err_unexpected,
  output logic             err_timeout,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] err_count
);
  import ready_responder_pkg::*;

  localparam int unsigned      RANGE    = MAX_BUSY - MIN_BUSY + 1;
  localparam logic [7:0]       MIN_B8   = 8'(MIN_BUSY);
  localparam int               TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  resp_state_e      state_q, state_d;
  logic [7:0]       busy_q, busy_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             accepted_q, accepted_d;
  logic             err_unexp_q, err_unexp_d;
  logic             err_tmo_q, err_tmo_d;
  logic [CNT_W-1:0] req_count_q, req_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             accept;
  logic [15:0]      lfsr_state;
  logic [7:0]       busy_len;

  assign accept = (state_q == ST_READY) && request;

  // The service length uses the pre-advance LFSR value; the LFSR steps on the same edge.
  assign busy_len = MIN_B8 + 8'(32'(lfsr_state[7:0]) % RANGE);

  resp_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step_i  (accept),
    .state_o (lfsr_state)
  );

  // Next-state, service/timeout counters, event pulses and counters.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    tmo_d       = tmo_q;
    accepted_d  = 1'b0;
    err_unexp_d = 1'b0;
    err_tmo_d   = 1'b0;
    req_count_d = req_count_q;
    err_count_d = err_count_q;

    case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_d = ST_READY;
          tmo_d   = '0;
        end
      end
      ST_READY: begin
        if (request) begin
          // Accept is unconditional on enable: ready was already offered.
          state_d     = ST_BUSY;
          accepted_d  = 1'b1;
          busy_d      = busy_len;
          req_count_d = CNT_W'(sat_inc(32'(req_count_q), 32'(CNT_MAX)));
        end else if (!enable) begin
          state_d = ST_OFF;
        end else if (tmo_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BUSY: begin
        // Counter holds the remaining low cycles; leave on the last one.
        if (busy_q <= 8'd1) begin
          state_d = enable ? ST_READY : ST_OFF;
          tmo_d   = '0;
        end else begin
          busy_d = busy_q - 8'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // A request while ready is low is flagged and otherwise ignored.
    if (request && (state_q != ST_READY)) begin
      err_unexp_d = 1'b1;
    end

    // The two error sources are mutually exclusive, so at most one count per cycle.
    if (err_unexp_d || err_tmo_d) begin
      err_count_d = CNT_W'(sat_inc(32'(err_count_q), 32'(CNT_MAX)));
    end
  end

  // Registered state and outputs; reset also aborts any service in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      busy_q      <= '0;
      tmo_q       <= '0;
      accepted_q  <= 1'b0;
      err_unexp_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      req_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      accepted_q  <= accepted_d;
      err_unexp_q <= err_unexp_d;
      err_tmo_q   <= err_tmo_d;
      req_count_q <= req_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign ready          = (state_q == ST_READY);
  assign accepted       = accepted_q;
  assign err_unexpected = err_unexp_q;
  assign err_timeout    = err_tmo_q;
  assign req_count      = req_count_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_ready_responder.sv
// Directed bench: fixed-latency instance, default random-latency instance,
// and a 2-bit counter instance for saturation.
module tb_ready_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed service time of 4 cycles.
  logic rst_f, en_f, req_f, rdy_f, acc_f, eu_f, et_f;
  logic [15:0] rc_f, ec_f;
  // Default parameters.
  logic rst_d, en_d, req_d, rdy_d, acc_d, eu_d, et_d;
  logic [15:0] rc_d, ec_d;
  // 2-bit counters, 1-cycle service.
  logic rst_s, en_s, req_s, rdy_s, acc_s, eu_s, et_s;
  logic [1:0] rc_s, ec_s;

  ready_responder #(.MIN_BUSY(4), .MAX_BUSY(4), .TIMEOUT(32), .CNT_W(16)) dut_fix (
    .clk(clk), .rst(rst_f), .enable(en_f), .request(req_f), .ready(rdy_f),
    .accepted(acc_f), .err_unexpected(eu_f), .err_timeout(et_f),
    .req_count(rc_f), .err_count(ec_f));

  ready_responder dut_def (
    .clk(clk), .rst(rst_d), .enable(en_d), .request(req_d), .ready(rdy_d),
    .accepted(acc_d), .err_unexpected(eu_d), .err_timeout(et_d),
    .req_count(rc_d), .err_count(ec_d));

  ready_responder #(.MIN_BUSY(1), .MAX_BUSY(1), .TIMEOUT(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst_s), .enable(en_s), .request(req_s), .ready(rdy_s),
    .accepted(acc_s), .err_unexpected(eu_s), .err_timeout(et_s),
    .req_count(rc_s), .err_count(ec_s));

  int tests = 0;
  int fails = 0;
  logic [15:0] mdl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference Galois LFSR step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic gap_f(input int start, output int n);
    n = start;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (rdy_f) break;
      n++;
    end
  endtask

  task automatic gap_d(input int start, output int n);
    n = start;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (rdy_d) break;
      n++;
    end
  endtask

  // One request on the default instance, checked against the reference LFSR.
  task automatic do_req_d(input int idx);
    int d;
    int n;
    int exp_len;
    d = $urandom_range(15, 5);
    repeat (d) tick();
    check("d_ready_before_req", rdy_d, 1);
    req_d = 1'b1;
    tick();
    req_d = 1'b0;
    check("d_accept", acc_d, 1);
    exp_len = 2 + int'(mdl[7:0]) % 8;
    mdl = lfsr_next(mdl);
    gap_d(1, n);
    check("d_gap_len", n, exp_len);
    check("d_gap_range", (n >= 2 && n <= 9) ? 1 : 0, 1);
    $display("[TB] req %0d delay %0d gap %0d", idx, d, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int extra;
    rst_f = 1; rst_d = 1; rst_s = 1;
    en_f = 0; en_d = 0; en_s = 0;
    req_f = 0; req_d = 0; req_s = 0;
    tick(); tick();

    // Reset state.
    check("f_rst_ready", rdy_f, 0);
    check("f_rst_acc", acc_f, 0);
    check("f_rst_rc", rc_f, 0);
    check("f_rst_ec", ec_f, 0);
    rst_f = 0;
    tick();
    check("f_off_no_enable", rdy_f, 0);

    // Basic accept with 4-cycle service.
    en_f = 1;
    tick();
    check("f_ready_rise", rdy_f, 1);
    req_f = 1;
    tick();
    req_f = 0;
    check("f_accept", acc_f, 1);
    check("f_ready_drop", rdy_f, 0);
    gap_f(1, n);
    check("f_gap4", n, 4);
    check("f_rc1", rc_f, 1);
    check("f_acc_pulse", acc_f, 0);

    // Request held two cycles.
    req_f = 1;
    tick();
    check("f_hold_accept", acc_f, 1);
    tick();
    req_f = 0;
    check("f_hold_unexp", eu_f, 1);
    check("f_hold_no_acc", acc_f, 0);
    check("f_hold_ec", ec_f, 1);
    tick();
    check("f_unexp_pulse", eu_f, 0);
    gap_f(3, n);
    check("f_hold_gap4", n, 4);
    check("f_rc2", rc_f, 2);

    // Timeout pulses every 32 READY cycles.
    extra = 0;
    for (int i = 1; i <= 96; i++) begin
      tick();
      if (i % 32 == 0) check("f_tmo_pulse", et_f, 1);
      else if (et_f) extra++;
      if (!rdy_f) extra++;
    end
    check("f_tmo_extra", extra, 0);
    check("f_tmo_ec", ec_f, 4);
    check("f_tmo_ready", rdy_f, 1);

    // Enable dropped during service.
    req_f = 1;
    tick();
    req_f = 0;
    en_f = 0;
    repeat (8) tick();
    check("f_off_after_busy", rdy_f, 0);
    en_f = 1;
    tick();
    check("f_reenable", rdy_f, 1);
    en_f = 0;
    tick();
    check("f_ready_to_off", rdy_f, 0);
    check("f_rc3", rc_f, 3);
    check("f_ec4", ec_f, 4);

    // Default instance: 100 random-spaced requests.
    mdl = 16'hACE1;
    rst_d = 0;
    en_d = 1;
    tick();
    check("d_ready_rise", rdy_d, 1);
    for (int k = 1; k <= 100; k++) do_req_d(k);
    check("d_rc100", rc_d, 100);
    check("d_ec0", ec_d, 0);

    // Reset mid-service after five accepts.
    rst_d = 1;
    tick();
    rst_d = 0;
    mdl = 16'hACE1;
    tick();
    for (int k = 1; k <= 4; k++) do_req_d(k);
    repeat (6) tick();
    req_d = 1;
    tick();
    req_d = 0;
    check("d_rc5", rc_d, 5);
    tick();
    rst_d = 1;
    tick();
    check("d_mid_rst_ready", rdy_d, 0);
    check("d_mid_rst_acc", acc_d, 0);
    check("d_mid_rst_eu", eu_d, 0);
    check("d_mid_rst_et", et_d, 0);
    check("d_mid_rst_rc", rc_d, 0);
    check("d_mid_rst_ec", ec_d, 0);
    rst_d = 0;
    tick();
    check("d_post_rst_ready", rdy_d, 1);
    req_d = 1;
    tick();
    req_d = 0;
    check("d_post_rst_accept", acc_d, 1);
    gap_d(1, n);
    check("d_seed_gap", n, 3);

    // Saturation with 2-bit counters.
    rst_s = 0;
    en_s = 1;
    tick();
    check("s_ready_rise", rdy_s, 1);
    for (int k = 0; k < 5; k++) begin
      req_s = 1;
      tick();
      req_s = 0;
      tick();
    end
    check("s_rc_sat", rc_s, 3);
    en_s = 0;
    tick();
    req_s = 1;
    repeat (5) tick();
    req_s = 0;
    check("s_ec_sat", ec_s, 3);
    check("s_rc_hold", rc_s, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
